cc_snoop_ctrl: RTL and testbench



---
 rtl/cc_snoop_ctrl_pkg.sv | 25 ++
 rtl/cc_mesi_next_state.sv | 50 +++++
 rtl/cc_snoop_ctrl.sv | 148 ++++++++++++++
 tb/tb_cc_snoop_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_snoop_ctrl_pkg.sv
// Shared coherence types for the snoop controller and the requester-side miss path.
// Holds the MESI end-state encoding, bus operations and block geometry.
package cc_snoop_ctrl_pkg;

    localparam int BLOCK_SIZE     = 2;
    localparam int WORD_W         = 32;
    localparam int BLOCK_OFF_BITS = $clog2(BLOCK_SIZE) + 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } cc_end_state;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_RSVD = 2'd3
    } cc_bus_op_t;

endpackage

// File: rtl/cc_mesi_next_state.sv
// Combinational MESI decode: current line state from status bits, end state and flush need for a bus op.
// Zero latency, no flow control.
module cc_mesi_next_state
    import cc_snoop_ctrl_pkg::*;
(
    input  logic        valid_i,
    input  logic        exclusive_i,
    input  logic        dirty_i,
    input  logic        hit_i,
    input  cc_bus_op_t  op_i,
    output cc_end_state prev_state_o,
    output cc_end_state next_state_o,
    output logic        flush_o
);

    cc_end_state prev;

    always_comb begin
        prev = INVALID;
        if (hit_i && valid_i) begin
            if (dirty_i)
                prev = MODIFIED;
            else if (exclusive_i)
                prev = EXCLUSIVE;
            else
                prev = SHARED;
        end
    end

    always_comb begin
        next_state_o = prev;
        flush_o      = 1'b0;
        case (op_i)
            BUS_RD: begin
                next_state_o = (prev == INVALID) ? INVALID : SHARED;
                flush_o      = (prev == MODIFIED);
            end
            BUS_RDX: begin
                next_state_o = INVALID;
                flush_o      = (prev == MODIFIED);
            end
            BUS_UPGR: next_state_o = INVALID;
            // reserved op leaves the line untouched
            default: next_state_o = prev;
        endcase
    end

    assign prev_state_o = prev;

endmodule

// File: rtl/cc_snoop_ctrl.sv
// Snoop side of the L1 coherence interface: look up, commit MESI end state, flush dirty block, respond.
// Response 2 cycles after accept (2+BLOCK_SIZE with flush); flush words and response hold until accepted.
module cc_snoop_ctrl #(
    parameter int BLOCK_SIZE = 2,
    parameter int WORD_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              bus_req,
    output logic              bus_ready,
    input  logic [WORD_W-1:0] bus_addr,
    input  logic [1:0]        bus_op,
    output logic              bus_data_valid,
    output logic [WORD_W-1:0] bus_data,
    input  logic              bus_data_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic              rsp_flushed,
    output logic [1:0]        rsp_prev_state,
    output logic              miss_pending,
    output logic [WORD_W-1:0] addr,
    output logic [1:0]        state_transfer,
    output logic              snoop_req,
    input  logic              valid,
    input  logic              exclusive,
    input  logic              dirty,
    input  logic              snoop_hit,
    input  logic [WORD_W-1:0] requested_data,
    input  logic              write_req,
    input  logic              dWEN
);
    import cc_snoop_ctrl_pkg::*;

    localparam int                OFF_BITS = $clog2(BLOCK_SIZE) + 2;
    localparam int                IDX_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(BLOCK_SIZE - 1);
    localparam logic [WORD_W-1:0] OFF_MASK = {{(WORD_W-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FLUSH, S_RESP} fsm_t;

    fsm_t              state_q;
    cc_bus_op_t        op_q;
    cc_end_state       st_q, prev_q;
    logic [WORD_W-1:0] addr_q;
    logic [IDX_W-1:0]  idx_q;
    logic              hit_q, flushed_q, snoop_req_q, bdv_q, rsp_valid_q, miss_q;
    cc_end_state       lk_prev, lk_next;
    logic              lk_flush;

    cc_mesi_next_state u_mesi (
        .valid_i      (valid),
        .exclusive_i  (exclusive),
        .dirty_i      (dirty),
        .hit_i        (snoop_hit),
        .op_i         (op_q),
        .prev_state_o (lk_prev),
        .next_state_o (lk_next),
        .flush_o      (lk_flush)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            op_q        <= BUS_RD;
            st_q        <= INVALID;
            prev_q      <= INVALID;
            addr_q      <= '0;
            idx_q       <= '0;
            hit_q       <= 1'b0;
            flushed_q   <= 1'b0;
            snoop_req_q <= 1'b0;
            bdv_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            miss_q <= write_req;
            case (state_q)
                S_IDLE: begin
                    if (bus_req && !dWEN) begin
                        state_q     <= S_LOOKUP;
                        addr_q      <= bus_addr & OFF_MASK;
                        op_q        <= cc_bus_op_t'(bus_op);
                        idx_q       <= '0;
                        snoop_req_q <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    hit_q  <= valid & snoop_hit;
                    prev_q <= lk_prev;
                    st_q   <= lk_next;
                    if (lk_flush) begin
                        state_q <= S_FLUSH;
                        idx_q   <= '0;
                        bdv_q   <= 1'b1;
                    end else begin
                        state_q     <= S_RESP;
                        snoop_req_q <= 1'b0;
                        addr_q      <= '0;
                        st_q        <= INVALID;
                        rsp_valid_q <= 1'b1;
                        flushed_q   <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (bus_data_ready) begin
                        if (idx_q == IDX_LAST) begin
                            state_q     <= S_RESP;
                            snoop_req_q <= 1'b0;
                            bdv_q       <= 1'b0;
                            addr_q      <= '0;
                            st_q        <= INVALID;
                            rsp_valid_q <= 1'b1;
                            flushed_q   <= 1'b1;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            addr_q <= addr_q + WORD_W'(4);
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        flushed_q   <= 1'b0;
                        hit_q       <= 1'b0;
                        prev_q      <= INVALID;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // LOOKUP shows the freshly decoded end state; the registered copy keeps it stable through FLUSH
    assign state_transfer = (state_q == S_LOOKUP) ? lk_next : st_q;
    assign bus_ready      = (state_q == S_IDLE) && !dWEN && !RST;
    assign snoop_req      = snoop_req_q;
    assign addr           = addr_q;
    assign bus_data_valid = bdv_q;
    assign bus_data       = bdv_q ? requested_data : '0;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_hit        = rsp_valid_q & hit_q;
    assign rsp_flushed    = rsp_valid_q & flushed_q;
    assign rsp_prev_state = rsp_valid_q ? prev_q : INVALID;
    assign miss_pending   = miss_q;

endmodule

// File: tb/tb_cc_snoop_ctrl.sv
module tb_cc_snoop_ctrl;
    import cc_snoop_ctrl_pkg::*;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST, bus_req, bus_ready, bus_data_valid, bus_data_ready, rsp_valid, rsp_ready;
    logic       rsp_hit, rsp_flushed, miss_pending, snoop_req;
    logic       valid, exclusive, dirty, snoop_hit, write_req, dWEN;
    logic [1:0] bus_op, rsp_prev_state, state_transfer;
    word_t      bus_addr, bus_data, addr, requested_data, dbase;

    // cache model: each word holds dbase plus its word address
    assign requested_data = dbase + (addr >> 2);

    logic rand_mode = 1'b0;
    logic r_bdr = 1'b1, r_rr = 1'b1, d_bdr, d_rr;
    assign bus_data_ready = rand_mode ? r_bdr : d_bdr;
    assign rsp_ready      = rand_mode ? r_rr  : d_rr;

    cc_snoop_ctrl #(.BLOCK_SIZE(BLOCK_SIZE), .WORD_W(WORD_W)) dut (
        .CLK(CLK), .RST(RST), .bus_req(bus_req), .bus_ready(bus_ready),
        .bus_addr(bus_addr), .bus_op(bus_op), .bus_data_valid(bus_data_valid),
        .bus_data(bus_data), .bus_data_ready(bus_data_ready), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_flushed(rsp_flushed),
        .rsp_prev_state(rsp_prev_state), .miss_pending(miss_pending), .addr(addr),
        .state_transfer(state_transfer), .snoop_req(snoop_req), .valid(valid),
        .exclusive(exclusive), .dirty(dirty), .snoop_hit(snoop_hit),
        .requested_data(requested_data), .write_req(write_req), .dWEN(dWEN)
    );

    typedef struct { logic hit; logic flushed; logic [1:0] prev; } rsp_t;
    typedef struct { word_t a; word_t d; } wrd_t;
    rsp_t rsp_q[$];
    wrd_t wrd_q[$];

    localparam word_t BLK_MASK = ~word_t'((1 << BLOCK_OFF_BITS) - 1);
    logic [1:0] exp_st;
    word_t      exp_base;
    int checks = 0, failures = 0, rsp_cnt = 0;
    logic wr_s = 1'b0, rst_s = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_prev(input logic v, input logic e, input logic d, input logic h);
        if (!(v && h)) return INVALID;
        if (d) return MODIFIED;
        return e ? EXCLUSIVE : SHARED;
    endfunction

    function automatic logic [1:0] ref_next(input logic [1:0] prev, input logic [1:0] op);
        case (op)
            2'd0:       return (prev == INVALID) ? INVALID : SHARED;
            2'd1, 2'd2: return INVALID;
            default:    return prev;
        endcase
    endfunction

    always @(posedge CLK) begin
        wr_s  <= write_req;
        rst_s <= RST;
        if (rand_mode) begin
            #1;
            r_bdr = ($urandom_range(0, 3) != 0);
            r_rr  = ($urandom_range(0, 2) != 0);
        end
    end

    // monitor: compares every DUT output event against the scoreboard
    always @(negedge CLK) begin
        rsp_t r;
        wrd_t w;
        if (!rst_s) chk("miss_pending", 32'(miss_pending), 32'(wr_s));
        if (!RST) begin
            if (snoop_req) begin
                chk("state_transfer", 32'(state_transfer), 32'(exp_st));
                chk("addr_block", addr & BLK_MASK, exp_base);
            end
            if (bus_data_valid && bus_data_ready) begin
                chk("flush_word_expected", 32'(wrd_q.size() != 0), 32'd1);
                if (wrd_q.size() != 0) begin
                    w = wrd_q.pop_front();
                    chk("flush_addr", addr, w.a);
                    chk("flush_data", bus_data, w.d);
                end
            end
            if (rsp_valid && rsp_ready) begin
                chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    r = rsp_q.pop_front();
                    chk("rsp_hit", 32'(rsp_hit), 32'(r.hit));
                    chk("rsp_flushed", 32'(rsp_flushed), 32'(r.flushed));
                    chk("rsp_prev_state", 32'(rsp_prev_state), 32'(r.prev));
                end
                rsp_cnt++;
            end
        end
    end

    task automatic set_line(input word_t a, input logic v, input logic e, input logic d, input logic h,
                            input logic [1:0] op, output logic fl);
        logic [1:0] p;
        word_t base;
        p    = ref_prev(v, e, d, h);
        fl   = (p == MODIFIED) && (op == 2'd0 || op == 2'd1);
        base = a & BLK_MASK;
        valid = v; exclusive = e; dirty = d; snoop_hit = h;
        exp_st = ref_next(p, op);
        exp_base = base;
        if (fl)
            for (int i = 0; i < BLOCK_SIZE; i++)
                wrd_q.push_back('{a: base + 32'(4 * i), d: dbase + ((base + 32'(4 * i)) >> 2)});
        rsp_q.push_back('{hit: v && h, flushed: fl, prev: p});
    endtask

    task automatic do_snoop(input word_t a, input logic [1:0] op, input logic v, input logic e,
                            input logic d, input logic h, input int ndwen, input logic chk_lat);
        logic fl;
        int lat, start, n;
        set_line(a, v, e, d, h, op, fl);
        bus_addr = a; bus_op = op; bus_req = 1'b1; dWEN = (ndwen > 0);
        for (int i = 0; i < ndwen; i++) begin
            @(negedge CLK); chk("bus_ready_during_dwen", 32'(bus_ready), 32'd0);
            @(posedge CLK); #1;
        end
        dWEN = 1'b0;
        @(negedge CLK); chk("bus_ready_idle", 32'(bus_ready), 32'd1);
        start = rsp_cnt;
        @(posedge CLK); #1;
        bus_req = 1'b0; bus_addr = $urandom; bus_op = 2'($urandom);
        lat = 1;
        while (lat < 40) begin
            @(negedge CLK);
            if (rsp_valid) break;
            @(posedge CLK); #1;
            lat++;
        end
        if (chk_lat) chk("rsp_latency", 32'(lat), fl ? 32'(2 + BLOCK_SIZE) : 32'd2);
        n = 0;
        do begin
            @(posedge CLK);
            n++;
        end while (rsp_cnt == start && n < 400);
        chk("rsp_done", 32'(rsp_cnt - start), 32'd1);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic fl;
        RST = 1'b1; bus_req = 1'b0; bus_addr = '0; bus_op = 2'd0; d_bdr = 1'b1; d_rr = 1'b1;
        valid = 1'b0; exclusive = 1'b0; dirty = 1'b0; snoop_hit = 1'b0;
        write_req = 1'b0; dWEN = 1'b0; dbase = '0; exp_st = INVALID; exp_base = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK); chk("reset_bus_ready_in_reset", 32'(bus_ready), 32'd0);
        @(posedge CLK); #1; RST = 1'b0;
        @(negedge CLK);
        chk("reset_bus_ready", 32'(bus_ready), 32'd1);
        chk("reset_snoop_req", 32'(snoop_req), 32'd0);
        chk("reset_bus_data_valid", 32'(bus_data_valid), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_addr", addr, 32'd0);
        chk("reset_bus_data", bus_data, 32'd0);
        chk("reset_state_transfer", 32'(state_transfer), 32'(INVALID));
        chk("reset_rsp_prev", 32'(rsp_prev_state), 32'd0);
        @(posedge CLK); #1;

        // M line read: flushes 0xA0,0xA1 from 0x100/0x104, end state SHARED
        dbase = 32'h60;
        do_snoop(32'h104, BUS_RD, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        do_snoop(32'h2000_0010, BUS_RDX, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b1);
        do_snoop(32'h44, BUS_UPGR, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        do_snoop(32'hFFFF_FFFF, BUS_RSVD, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
        do_snoop(32'h1234_5679, BUS_RD, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        write_req = 1'b1;
        do_snoop(32'h80, BUS_RD, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1);
        write_req = 1'b0;

        // back-pressure on flush word 0, then on the response
        dbase = 32'h1000;
        set_line(32'h304, 1'b1, 1'b0, 1'b1, 1'b1, BUS_RD, fl);
        d_bdr = 1'b0; d_rr = 1'b0;
        bus_addr = 32'h304; bus_op = BUS_RD; bus_req = 1'b1;
        @(posedge CLK); #1; bus_req = 1'b0;
        @(posedge CLK); #1;
        repeat (2) begin
            @(negedge CLK);
            chk("stall_addr", addr, 32'h300);
            chk("stall_bus_data", bus_data, 32'h1000 + (32'h300 >> 2));
            chk("stall_bus_data_valid", 32'(bus_data_valid), 32'd1);
            chk("stall_state_transfer", 32'(state_transfer), 32'(SHARED));
            @(posedge CLK); #1;
        end
        d_bdr = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        repeat (3) begin
            @(negedge CLK);
            chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_hold_flushed", 32'(rsp_flushed), 32'd1);
            chk("rsp_hold_prev", 32'(rsp_prev_state), 32'(MODIFIED));
            chk("rsp_hold_bus_ready", 32'(bus_ready), 32'd0);
            @(posedge CLK); #1;
        end
        d_rr = 1'b1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("after_rsp_bus_ready", 32'(bus_ready), 32'd1);
        @(posedge CLK); #1;

        // reset while streaming word 1 of a flush
        dbase = '0;
        set_line(32'h204, 1'b1, 1'b0, 1'b1, 1'b1, BUS_RD, fl);
        bus_addr = 32'h204; bus_op = BUS_RD; bus_req = 1'b1;
        @(posedge CLK); #1; bus_req = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1; d_bdr = 1'b0;
        @(negedge CLK); chk("flush_idx1_addr", addr, 32'h204);
        RST = 1'b1;
        @(posedge CLK); #1; RST = 1'b0;
        @(negedge CLK);
        chk("midrst_snoop_req", 32'(snoop_req), 32'd0);
        chk("midrst_bus_data_valid", 32'(bus_data_valid), 32'd0);
        chk("midrst_state_transfer", 32'(state_transfer), 32'(INVALID));
        chk("midrst_bus_ready", 32'(bus_ready), 32'(!dWEN));
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_addr", addr, 32'd0);
        wrd_q.delete();
        rsp_q.delete();
        d_bdr = 1'b1;
        @(posedge CLK); #1;

        rand_mode = 1'b1;
        for (int k = 0; k < 60; k++) begin
            dbase = $urandom;
            write_req = 1'($urandom);
            do_snoop($urandom, 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     ($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)), 1'b0);
        end
        rand_mode = 1'b0;
        write_req = 1'b0;
        repeat (2) @(posedge CLK);

        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        chk("word_queue_drained", 32'(wrd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
